// File: rtl/loc_pkg.sv
// Shared encodings for the maze-solver location datapath: command ops,
// direction codes, sticky error bit positions and controller FSM states.
package loc_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_MOVE  = 2'b01,
        OP_BACK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        DIR_YDEC = 2'b00,
        DIR_XINC = 2'b01,
        DIR_XDEC = 2'b10,
        DIR_YINC = 2'b11
    } dir_e;

    localparam int ERR_EDGE = 0;
    localparam int ERR_OVF  = 1;
    localparam int ERR_UNF  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_POP  = 1'b1
    } state_e;

endpackage

// File: rtl/loc_stack.sv
// Synchronous LIFO of visited locations with registered read data.
// A read (rd_en) latches the top entry; a later pop drops it from the count.
module loc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           rd_en,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wr_idx, top_idx;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign wr_idx  = AW'(cnt_q);
    assign top_idx = AW'(cnt_q - CW'(1));
    assign count   = cnt_q;
    assign rd_data = rd_data_q;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (push && !full)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !empty)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (rd_en && !empty)
                rd_data_q <= mem_q[top_idx];
        end
    end

    // NOTE: storage is deliberately not reset; entries above the count are never read.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/loc_tracker.sv
// Maze-solver location datapath: current {x,y}, candidate step, backtrack stack.
// Optional visited-cell map enabled by defining LOC_VISITED_MAP_EN.
module loc_tracker
    import loc_pkg::*;
#(
    parameter int COORD_W     = 4,
    parameter int STACK_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    input  logic [1:0]                         cmd_op,
    input  logic [1:0]                         dir,
    output logic                               cmd_ready,
    output logic [2*COORD_W-1:0]               cur_loc,
    output logic [2*COORD_W-1:0]               nxt_loc,
    output logic                               edge_hit,
    output logic                               stk_empty,
    output logic                               stk_full,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_cnt,
    output logic [2:0]                         err_flags
`ifdef LOC_VISITED_MAP_EN
    ,
    output logic                               nxt_visited
`endif
);

    localparam int LOC_W = 2*COORD_W;

    op_e                state_op;
    state_e             state_q, state_d;
    logic [LOC_W-1:0]   cur_loc_q, cur_loc_d, pop_data;
    logic [2:0]         err_q, err_d;
    logic [COORD_W-1:0] cur_x, cur_y, axis_val, axis_nxt;
    logic               accept, cmd_move, cmd_back, clear, move_ok, back_ok, pop_done;

    assign state_op = op_e'(cmd_op);
    assign cur_x    = cur_loc_q[LOC_W-1:COORD_W];
    assign cur_y    = cur_loc_q[COORD_W-1:0];

    // Odd-parity dir codes step along x; dir[0] selects increment over decrement.
    always_comb begin
        axis_val = (^dir) ? cur_x : cur_y;
        axis_nxt = dir[0] ? axis_val + COORD_W'(1) : axis_val - COORD_W'(1);
        edge_hit = dir[0] ? (&axis_val) : (axis_val == '0);
        nxt_loc  = (^dir) ? {axis_nxt, cur_y} : {cur_x, axis_nxt};
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (back_ok) state_d = ST_POP;
            ST_POP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        accept    = cmd_valid && cmd_ready;
        cmd_move  = accept && (state_op == OP_MOVE);
        cmd_back  = accept && (state_op == OP_BACK);
        clear     = accept && (state_op == OP_CLEAR);
        move_ok   = cmd_move && !edge_hit && !stk_full;
        back_ok   = cmd_back && !stk_empty;
        pop_done  = (state_q == ST_POP);
    end

    always_comb begin
        cur_loc_d = cur_loc_q;
        err_d     = err_q;
        if (clear) begin
            cur_loc_d = '0;
            err_d     = '0;
        end else if (pop_done) begin
            cur_loc_d = pop_data;
        end else if (cmd_move) begin
            if (edge_hit)      err_d[ERR_EDGE] = 1'b1;
            else if (stk_full) err_d[ERR_OVF]  = 1'b1;
            else               cur_loc_d       = nxt_loc;
        end else if (cmd_back && stk_empty) begin
            err_d[ERR_UNF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_loc_q <= '0;
            err_q     <= '0;
        end else begin
            cur_loc_q <= cur_loc_d;
            err_q     <= err_d;
        end
    end

    loc_stack #(
        .WIDTH (LOC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear),
        .push      (move_ok),
        .push_data (cur_loc_q),
        .rd_en     (back_ok),
        .pop       (pop_done),
        .rd_data   (pop_data),
        .count     (stk_cnt),
        .empty     (stk_empty),
        .full      (stk_full)
    );

    assign cur_loc   = cur_loc_q;
    assign err_flags = err_q;

`ifdef LOC_VISITED_MAP_EN
    localparam int MAP_W = 1 << LOC_W;

    logic [MAP_W-1:0] map_q, map_d;

    // Origin counts as visited whenever the location returns to it via reset or CLEAR.
    always_comb begin
        map_d = map_q;
        if (clear)        map_d = MAP_W'(1);
        else if (move_ok) map_d[nxt_loc] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) map_q <= MAP_W'(1);
        else     map_q <= map_d;
    end

    assign nxt_visited = map_q[nxt_loc];
`endif

endmodule

// File: tb/tb_loc_tracker.sv
// Self-checking bench for loc_tracker (COORD_W=4, STACK_DEPTH=4): a reference
// model pushes expected state to a scoreboard as each command is driven.
module tb_loc_tracker;
    import loc_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] loc;
        logic [2:0] cnt;
        logic [2:0] err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] dir = 2'b00;
    logic       cmd_ready, edge_hit, stk_empty, stk_full;
    logic [7:0] cur_loc, nxt_loc;
    logic [2:0] stk_cnt, err_flags;
`ifdef LOC_VISITED_MAP_EN
    logic       nxt_visited;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] m_loc;
    logic [7:0] m_stk[$];
    logic [2:0] m_err;
    exp_t       sb[$];

    loc_tracker #(.COORD_W(4), .STACK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .dir       (dir),
        .cmd_ready (cmd_ready),
        .cur_loc   (cur_loc),
        .nxt_loc   (nxt_loc),
        .edge_hit  (edge_hit),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_cnt   (stk_cnt),
        .err_flags (err_flags)
`ifdef LOC_VISITED_MAP_EN
        ,
        .nxt_visited (nxt_visited)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_step(input logic [7:0] loc, input logic [1:0] d,
                                       output logic [7:0] nl, output bit eh);
        int x = int'(loc[7:4]);
        int y = int'(loc[3:0]);
        case (d)
            2'd0:    begin eh = (y == 0);  y = (y + 15) % 16; end
            2'd1:    begin eh = (x == 15); x = (x + 1) % 16;  end
            2'd2:    begin eh = (x == 0);  x = (x + 15) % 16; end
            default: begin eh = (y == 15); y = (y + 1) % 16;  end
        endcase
        nl = {4'(x), 4'(y)};
    endfunction

    function automatic void model_reset();
        m_loc = 8'h00;
        m_stk.delete();
        m_err = 3'b000;
        sb.delete();
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Drives one command, updates the model and queues the expected end state.
    task automatic send(input logic [1:0] op, input logic [1:0] d, output bit popping);
        logic [7:0] nl;
        bit         eh;
        int         waited = 0;
        while (!cmd_ready && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: got cmd_ready=%b want 1", cmd_ready);
        end
        popping = 1'b0;
        case (op)
            OP_MOVE: begin
                model_step(m_loc, d, nl, eh);
                if (eh)                       m_err[ERR_EDGE] = 1'b1;
                else if (m_stk.size() == DEPTH) m_err[ERR_OVF] = 1'b1;
                else begin
                    m_stk.push_back(m_loc);
                    m_loc = nl;
                end
            end
            OP_BACK: begin
                if (m_stk.size() == 0) m_err[ERR_UNF] = 1'b1;
                else begin
                    m_loc = m_stk.pop_back();
                    popping = 1'b1;
                end
            end
            OP_CLEAR: begin
                m_loc = 8'h00;
                m_stk.delete();
                m_err = 3'b000;
            end
            default: ;
        endcase
        sb.push_back('{loc: m_loc, cnt: 3'(m_stk.size()), err: m_err});
        cmd_op = op;
        dir = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cur_loc, stk_cnt, err_flags} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state: got loc=%h cnt=%0d err=%b want loc=00 cnt=0 err=000", cur_loc, stk_cnt, err_flags);
        end
        checks++;
        if ({stk_empty, stk_full, cmd_ready} !== 3'b101) begin
            failures++;
            $display("FAIL reset_flags: got empty/full/ready=%b%b%b want 101", stk_empty, stk_full, cmd_ready);
        end
    endtask

    task automatic test_move_x();
        exp_t       e;
        bit         p;
        logic [7:0] nl;
        bit         eh;
        for (int i = 0; i < 3; i++) begin
            send(OP_MOVE, DIR_XINC, p);
            e = sb.pop_front();
            checks++;
            if ({cur_loc, stk_cnt, err_flags} !== e) begin
                failures++;
                $display("FAIL move_x%0d: got loc=%h cnt=%0d err=%b want loc=%h cnt=%0d err=%b",
                         i, cur_loc, stk_cnt, err_flags, e.loc, e.cnt, e.err);
            end
        end
        // Candidate location for every direction from 8'h30.
        for (int d = 0; d < 4; d++) begin
            dir = 2'(d);
            #1;
            model_step(m_loc, 2'(d), nl, eh);
            checks++;
            if ({nxt_loc, edge_hit} !== {nl, eh}) begin
                failures++;
                $display("FAIL nxt_dir%0d: got nxt=%h edge=%b want nxt=%h edge=%b", d, nxt_loc, edge_hit, nl, eh);
            end
        end
    endtask

    task automatic test_edge();
        exp_t e;
        bit   p;
        reset_dut();
        dir = DIR_YDEC;
        #1;
        checks++;
        if ({nxt_loc, edge_hit} !== {8'h0F, 1'b1}) begin
            failures++;
            $display("FAIL edge_comb: got nxt=%h edge=%b want nxt=0f edge=1", nxt_loc, edge_hit);
        end
        dir = DIR_XDEC;
        #1;
        checks++;
        if ({nxt_loc, edge_hit} !== {8'hF0, 1'b1}) begin
            failures++;
            $display("FAIL edge_xdec: got nxt=%h edge=%b want nxt=f0 edge=1", nxt_loc, edge_hit);
        end
        send(OP_MOVE, DIR_YDEC, p);
        e = sb.pop_front();
        checks++;
        if ({cur_loc, stk_cnt, err_flags} !== e) begin
            failures++;
            $display("FAIL edge_move: got loc=%h cnt=%0d err=%b want loc=%h cnt=%0d err=%b",
                     cur_loc, stk_cnt, err_flags, e.loc, e.cnt, e.err);
        end
    endtask

    task automatic test_full();
        exp_t e;
        bit   p;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            send(OP_MOVE, DIR_YINC, p);
            e = sb.pop_front();
            checks++;
            if ({cur_loc, stk_cnt, err_flags} !== e) begin
                failures++;
                $display("FAIL full_move%0d: got loc=%h cnt=%0d err=%b want loc=%h cnt=%0d err=%b",
                         i, cur_loc, stk_cnt, err_flags, e.loc, e.cnt, e.err);
            end
        end
        checks++;
        if (stk_full !== 1'b1) begin
            failures++;
            $display("FAIL full_flag: got stk_full=%b want 1", stk_full);
        end
    endtask

    task automatic test_back();
        exp_t e;
        bit   p;
        for (int i = 0; i < 5; i++) begin
            send(OP_BACK, DIR_XINC, p);
            if (p) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL back_busy%0d: got cmd_ready=%b want 0", i, cmd_ready);
                end
                @(posedge clk); #1;
            end
            e = sb.pop_front();
            checks++;
            if ({cur_loc, stk_cnt, err_flags, cmd_ready} !== {e, 1'b1}) begin
                failures++;
                $display("FAIL back%0d: got loc=%h cnt=%0d err=%b rdy=%b want loc=%h cnt=%0d err=%b rdy=1",
                         i, cur_loc, stk_cnt, err_flags, cmd_ready, e.loc, e.cnt, e.err);
            end
        end
        checks++;
        if (stk_empty !== 1'b1) begin
            failures++;
            $display("FAIL back_empty: got stk_empty=%b want 1", stk_empty);
        end
    endtask

    task automatic test_back_reset();
        bit p;
        reset_dut();
        send(OP_MOVE, DIR_XINC, p);
        send(OP_MOVE, DIR_XINC, p);
        send(OP_BACK, DIR_XINC, p);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({cur_loc, stk_cnt, cmd_ready} !== {8'h00, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL rst_in_pop: got loc=%h cnt=%0d rdy=%b want loc=00 cnt=0 rdy=1", cur_loc, stk_cnt, cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({cur_loc, stk_cnt, cmd_ready} !== {8'h00, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL rst_in_pop_hold: got loc=%h cnt=%0d rdy=%b want loc=00 cnt=0 rdy=1", cur_loc, stk_cnt, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops[8]  = '{OP_MOVE, OP_MOVE, OP_BACK, OP_MOVE, OP_NOP, OP_MOVE, OP_MOVE, OP_CLEAR};
        logic [1:0] dirs[8] = '{DIR_YINC, DIR_XINC, DIR_YDEC, DIR_XDEC, DIR_XINC, DIR_YDEC, DIR_XDEC, DIR_YINC};
        exp_t e;
        bit   p;
        for (int i = 0; i < 8; i++) begin
            send(ops[i], dirs[i], p);
            if (p) begin
                @(posedge clk); #1;
            end
            e = sb.pop_front();
            checks++;
            if ({cur_loc, stk_cnt, err_flags} !== e) begin
                failures++;
                $display("FAIL b2b%0d: got loc=%h cnt=%0d err=%b want loc=%h cnt=%0d err=%b",
                         i, cur_loc, stk_cnt, err_flags, e.loc, e.cnt, e.err);
            end
        end
        // A MOVE presented without cmd_valid must leave everything untouched.
        send(OP_MOVE, DIR_YINC, p);
        e = sb.pop_front();
        cmd_op = OP_MOVE;
        dir = DIR_XINC;
        @(posedge clk); #1;
        checks++;
        if ({cur_loc, stk_cnt, err_flags} !== e) begin
            failures++;
            $display("FAIL invalid_hold: got loc=%h cnt=%0d err=%b want loc=%h cnt=%0d err=%b",
                     cur_loc, stk_cnt, err_flags, e.loc, e.cnt, e.err);
        end
    endtask

`ifdef LOC_VISITED_MAP_EN
    task automatic test_visited();
        bit p;
        reset_dut();
        send(OP_MOVE, DIR_XINC, p);
        send(OP_BACK, DIR_XINC, p);
        @(posedge clk); #1;
        sb.delete();
        dir = DIR_XINC;
        #1;
        checks++;
        if (nxt_visited !== 1'b1) begin
            failures++;
            $display("FAIL visited_x: got nxt_visited=%b want 1", nxt_visited);
        end
        dir = DIR_YINC;
        #1;
        checks++;
        if (nxt_visited !== 1'b0) begin
            failures++;
            $display("FAIL visited_y: got nxt_visited=%b want 0", nxt_visited);
        end
    endtask
`endif

    initial begin
        reset_dut();
        test_reset();
        test_move_x();
        test_edge();
        test_full();
        test_back();
        test_back_reset();
        test_back_to_back();
`ifdef LOC_VISITED_MAP_EN
        test_visited();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
